// File: rtl/telemetry_framer.sv
// Telemetry framer: snapshots masked sensor channels and streams them as a
// sequenced, length-prefixed, checksummed byte frame to a byte transmitter.
module telemetry_framer #(
  parameter int unsigned NUM_CH        = 14,
  parameter int unsigned CH_BYTES      = 3,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned PERIOD_CYCLES = 500000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*8*CH_BYTES-1:0]   ch_data,
  input  logic [NUM_CH-1:0]              ch_mask,
  input  logic                           trigger,
  input  logic                           auto_en,
  output logic [7:0]                     tx_data,
  output logic                           new_tx_data,
  input  logic                           tx_busy,
  output logic                           frame_active,
  output logic                           overrun,
  output logic [7:0]                     seq
);

  localparam int unsigned CH_W = 8 * CH_BYTES;
  localparam int unsigned DW   = NUM_CH * CH_W;
  localparam int unsigned CW   = $clog2(NUM_CH + 1);
  localparam int unsigned BW   = (CH_BYTES > 1) ? $clog2(CH_BYTES) : 1;
  localparam int unsigned PW   = $clog2(PERIOD_CYCLES);
  localparam logic [PW-1:0] PERIOD_RELOAD = PW'(PERIOD_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SNAP   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  localparam logic [2:0] P_SYNC = 3'd0;
  localparam logic [2:0] P_SEQ  = 3'd1;
  localparam logic [2:0] P_LEN  = 3'd2;
  localparam logic [2:0] P_PAY  = 3'd3;
  localparam logic [2:0] P_DONE = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [PW-1:0]     r_period;
  logic [DW-1:0]     r_snap_data;
  logic [NUM_CH-1:0] r_snap_mask;
  logic [7:0]        r_len;
  logic [7:0]        r_cks;
  logic [2:0]        r_phase;
  logic [CW-1:0]     r_ch;
  logic [BW-1:0]     r_bi;
  logic [7:0]        r_tx_data;
  logic              r_new_tx;
  logic              r_frame_active;
  logic              r_overrun;
  logic [7:0]        r_seq;

  logic              w_tick;
  logic              w_req;
  logic              w_found;
  logic [CW-1:0]     w_cur_ch;
  logic [CH_W-1:0]   w_ch_word;
  logic [7:0]        w_pay_byte;
  logic [7:0]        w_cks_byte;
  logic [7:0]        w_byte;
  logic              w_acc;
  logic [31:0]       w_pop;
  logic [7:0]        w_len;

  assign tx_data      = r_tx_data;
  assign new_tx_data  = r_new_tx;
  assign frame_active = r_frame_active;
  assign overrun      = r_overrun;
  assign seq          = r_seq;

  assign w_tick     = auto_en & (r_period == '0);
  assign w_req      = trigger | w_tick;
  assign w_cks_byte = 8'd0 - r_cks;

  // Free-running period timer, parked at reload while auto triggering is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= PERIOD_RELOAD;
    end else if (!auto_en || (r_period == '0)) begin
      r_period <= PERIOD_RELOAD;
    end else begin
      r_period <= r_period - PW'(1);
    end
  end

  always_comb begin
    w_pop = 32'd0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_pop = w_pop + 32'(ch_mask[k]);
    end
    w_len = 8'(w_pop * CH_BYTES);
  end

  // Next enabled channel at or after r_ch; none left means the CKS byte is due
  always_comb begin
    w_found  = 1'b0;
    w_cur_ch = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!w_found && r_snap_mask[k] && (CW'(k) >= r_ch)) begin
        w_found  = 1'b1;
        w_cur_ch = CW'(k);
      end
    end
  end

  always_comb begin
    w_ch_word  = '0;
    w_pay_byte = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (CW'(k) == w_cur_ch) w_ch_word = r_snap_data[k*CH_W +: CH_W];
    end
    for (int unsigned b = 0; b < CH_BYTES; b++) begin
      if (BW'(b) == r_bi) w_pay_byte = w_ch_word[(CH_BYTES-1-b)*8 +: 8];
    end
  end

  always_comb begin
    w_byte = w_cks_byte;
    w_acc  = 1'b0;
    case (r_phase)
      P_SYNC: w_byte = SYNC_BYTE;
      P_SEQ:  begin w_byte = r_seq; w_acc = 1'b1; end
      P_LEN:  begin w_byte = r_len; w_acc = 1'b1; end
      P_PAY:  begin
        w_byte = w_found ? w_pay_byte : w_cks_byte;
        w_acc  = w_found;
      end
      default: w_byte = w_cks_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_state_nxt = S_SNAP;
      S_SNAP:   w_state_nxt = S_LOAD;
      S_LOAD:   if (!tx_busy) w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_HOLD;
      S_HOLD:   w_state_nxt = S_DRAIN;
      S_DRAIN:  if (!tx_busy) w_state_nxt = (r_phase == P_DONE) ? S_IDLE : S_LOAD;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath: snapshot, byte sequencing, checksum and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_data    <= '0;
      r_snap_mask    <= '0;
      r_len          <= '0;
      r_cks          <= '0;
      r_phase        <= P_SYNC;
      r_ch           <= '0;
      r_bi           <= '0;
      r_tx_data      <= '0;
      r_new_tx       <= 1'b0;
      r_frame_active <= 1'b0;
      r_overrun      <= 1'b0;
      r_seq          <= '0;
    end else begin
      r_overrun <= w_req && (r_state != S_IDLE);
      r_new_tx  <= (r_state == S_LOAD) && !tx_busy;
      case (r_state)
        S_IDLE: if (w_req) r_frame_active <= 1'b1;
        S_SNAP: begin
          r_snap_data <= ch_data;
          r_snap_mask <= ch_mask;
          r_len       <= w_len;
          r_cks       <= '0;
          r_phase     <= P_SYNC;
          r_ch        <= '0;
          r_bi        <= '0;
        end
        S_LOAD: r_tx_data <= w_byte;
        S_STROBE: begin
          if (w_acc) r_cks <= r_cks + r_tx_data;
          case (r_phase)
            P_SYNC: r_phase <= P_SEQ;
            P_SEQ:  r_phase <= P_LEN;
            P_LEN:  r_phase <= P_PAY;
            P_PAY: begin
              if (!w_found) begin
                r_phase <= P_DONE;
              end else if (r_bi == BW'(CH_BYTES - 1)) begin
                r_bi <= '0;
                r_ch <= w_cur_ch + CW'(1);
              end else begin
                r_bi <= r_bi + BW'(1);
              end
            end
            default: r_phase <= P_DONE;
          endcase
        end
        S_DRAIN: begin
          if (!tx_busy && (r_phase == P_DONE)) begin
            r_frame_active <= 1'b0;
            r_seq          <= r_seq + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
